// File: rtl/spi_clk_config_seq.sv
// Loads per-chip register tables from ROM into the jitter-cleaner chips over the shared SPI engine, then pulses SYNC.
// Optional DONE watchdog: define SPI_SEQ_TIMEOUT_EN.
module spi_clk_config_seq #(
  parameter int unsigned NUM_CHIPS      = 3,
  parameter int unsigned WORD_AW        = 4,
  parameter int unsigned GAP_CYCLES     = 2,
  parameter int unsigned SYNC_CYCLES    = 4,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic                 CLK_1MHZ,
  input  logic                 RESET,
  input  logic                 START,
  input  logic                 ABORT,
  input  logic [NUM_CHIPS-1:0] CHIP_MASK,
  output logic [WORD_AW+1:0]   ROM_ADDR,
  input  logic [31:0]          ROM_DATA,
  output logic [31:0]          SPI_WORD,
  output logic                 SPI_GO,
  input  logic                 SPI_DONE,
  output logic [1:0]           SPI_SEL,
  output logic                 SYNC,
  output logic                 BUSY,
  output logic                 DONE,
  output logic                 ERROR,
  output logic [7:0]           WORDS_SENT
);

  typedef enum logic [3:0] {
    S_IDLE, S_FETCH, S_LOAD, S_GO, S_WAIT_DONE, S_GAP, S_NEXT_CHIP, S_SYNC_PULSE, S_FINISH
  } state_t;

  state_t               state;
  logic [1:0]           chip;
  logic [WORD_AW-1:0]   word;
  logic [NUM_CHIPS-1:0] mask_q;
  logic                 done_q;
  logic [7:0]           cnt;
  logic                 done_rise;
  logic                 first_found;
  logic [1:0]           first_chip;
  logic                 next_found;
  logic [1:0]           next_chip;

  // ROM address tracks the chip/word registers, so it is already valid during FETCH
  assign ROM_ADDR  = {chip, word};
  assign done_rise = SPI_DONE & ~done_q;

  always_comb begin
    first_found = 1'b0;
    first_chip  = '0;
    next_found  = 1'b0;
    next_chip   = '0;
    for (int unsigned i = 0; i < NUM_CHIPS; i++) begin
      if (CHIP_MASK[i] && !first_found) begin
        first_found = 1'b1;
        first_chip  = 2'(i);
      end
      if (mask_q[i] && (i > 32'(chip)) && !next_found) begin
        next_found = 1'b1;
        next_chip  = 2'(i);
      end
    end
  end

`ifdef SPI_SEQ_TIMEOUT_EN
  localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TO_W-1:0] to_cnt;
`else
  assign ERROR = 1'b0;
`endif

  always_ff @(posedge CLK_1MHZ) begin
    if (RESET) begin
      state      <= S_IDLE;
      chip       <= '0;
      word       <= '0;
      mask_q     <= '0;
      done_q     <= 1'b0;
      cnt        <= '0;
      SPI_WORD   <= '0;
      SPI_GO     <= 1'b0;
      SPI_SEL    <= '0;
      SYNC       <= 1'b0;
      BUSY       <= 1'b0;
      DONE       <= 1'b0;
      WORDS_SENT <= '0;
`ifdef SPI_SEQ_TIMEOUT_EN
      ERROR      <= 1'b0;
      to_cnt     <= '0;
`endif
    end else begin
      done_q <= SPI_DONE;
      SPI_GO <= 1'b0;
      DONE   <= 1'b0;
      if (ABORT) begin
        state <= S_IDLE;
        SYNC  <= 1'b0;
        BUSY  <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            if (START) begin
              BUSY       <= 1'b1;
              WORDS_SENT <= '0;
              mask_q     <= CHIP_MASK;
              word       <= '0;
              cnt        <= '0;
`ifdef SPI_SEQ_TIMEOUT_EN
              ERROR      <= 1'b0;
`endif
              if (first_found) begin
                chip  <= first_chip;
                state <= S_FETCH;
              end else begin
                SYNC  <= 1'b1;
                state <= S_SYNC_PULSE;
              end
            end
          end
          S_FETCH: state <= S_LOAD;
          S_LOAD: begin
            if (ROM_DATA == 32'hFFFF_FFFF) begin
              state <= S_NEXT_CHIP;
            end else begin
              SPI_WORD <= ROM_DATA;
              SPI_SEL  <= chip;
              SPI_GO   <= 1'b1;
              state    <= S_GO;
            end
          end
          S_GO: begin
            state <= S_WAIT_DONE;
`ifdef SPI_SEQ_TIMEOUT_EN
            to_cnt <= '0;
`endif
          end
          S_WAIT_DONE: begin
            if (done_rise) begin
              if (WORDS_SENT != 8'hFF) WORDS_SENT <= WORDS_SENT + 8'd1;
              cnt   <= '0;
              state <= S_GAP;
            end
`ifdef SPI_SEQ_TIMEOUT_EN
            else if (to_cnt == TO_W'(TIMEOUT_CYCLES - 1)) begin
              ERROR <= 1'b1;
              BUSY  <= 1'b0;
              state <= S_IDLE;
            end else begin
              to_cnt <= to_cnt + TO_W'(1);
            end
`endif
          end
          S_GAP: begin
            if (cnt == 8'(GAP_CYCLES - 1)) begin
              cnt <= '0;
              if (word == '1) begin
                state <= S_NEXT_CHIP;
              end else begin
                word  <= word + WORD_AW'(1);
                state <= S_FETCH;
              end
            end else begin
              cnt <= cnt + 8'd1;
            end
          end
          S_NEXT_CHIP: begin
            if (next_found) begin
              chip  <= next_chip;
              word  <= '0;
              state <= S_FETCH;
            end else begin
              SYNC  <= 1'b1;
              cnt   <= '0;
              state <= S_SYNC_PULSE;
            end
          end
          S_SYNC_PULSE: begin
            if (cnt == 8'(SYNC_CYCLES - 1)) begin
              SYNC  <= 1'b0;
              DONE  <= 1'b1;
              BUSY  <= 1'b0;
              state <= S_FINISH;
            end else begin
              cnt <= cnt + 8'd1;
            end
          end
          S_FINISH: state <= S_IDLE;
          default:  state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_spi_clk_config_seq.sv
// Self-checking bench for spi_clk_config_seq: table ROM, SPI engine model and a transfer-list reference model.
module tb_spi_clk_config_seq;

  localparam int NUM_CHIPS   = 3;
  localparam int WORD_AW     = 4;
  localparam int WORDS       = 16;
  localparam int GAP_CYCLES  = 2;
  localparam int SYNC_CYCLES = 4;
  localparam int TIMEOUT     = 64;

  logic        clk = 1'b0;
  logic        rst, start, abort;
  logic [2:0]  chip_mask;
  logic [5:0]  rom_addr;
  logic [31:0] rom_q;
  logic [31:0] spi_word;
  logic        spi_go, spi_done, sync, busy, done, error;
  logic [1:0]  spi_sel;
  logic [7:0]  words_sent;

  always #5 clk = ~clk;

  spi_clk_config_seq #(
    .NUM_CHIPS(NUM_CHIPS), .WORD_AW(WORD_AW), .GAP_CYCLES(GAP_CYCLES),
    .SYNC_CYCLES(SYNC_CYCLES), .TIMEOUT_CYCLES(TIMEOUT)
  ) dut (
    .CLK_1MHZ(clk), .RESET(rst), .START(start), .ABORT(abort), .CHIP_MASK(chip_mask),
    .ROM_ADDR(rom_addr), .ROM_DATA(rom_q), .SPI_WORD(spi_word), .SPI_GO(spi_go),
    .SPI_DONE(spi_done), .SPI_SEL(spi_sel), .SYNC(sync), .BUSY(busy), .DONE(done),
    .ERROR(error), .WORDS_SENT(words_sent)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Table ROM with one clock read latency
  logic [31:0] rom [0:63];
  always @(posedge clk) rom_q <= rom[rom_addr];

  // SPI engine: DONE drops on GO and rises spi_lat clocks later
  int spi_lat = 20;
  int spi_cnt = 0;
  bit spi_stuck = 0;
  always @(posedge clk) begin
    if (rst) begin
      spi_done <= 1'b0;
      spi_cnt  <= 0;
    end else if (spi_go) begin
      spi_done <= 1'b0;
      spi_cnt  <= spi_lat;
    end else if (spi_cnt > 0) begin
      spi_cnt <= spi_cnt - 1;
      if (spi_cnt == 1 && !spi_stuck) spi_done <= 1'b1;
    end
  end

  // Reference model: the ordered list of transfers the mask and tables imply
  typedef struct packed {
    logic [5:0]  addr;
    logic [31:0] data;
    logic [1:0]  sel;
  } xfer_t;
  xfer_t      exp_q[$];
  xfer_t      mon_e;
  int         exp_n, exp_words;
  logic [2:0] cur_mask;

  task automatic build_model(input logic [2:0] mask);
    exp_q.delete();
    for (int c = 0; c < NUM_CHIPS; c++) begin
      if (mask[c]) begin
        for (int w = 0; w < WORDS; w++) begin
          logic [5:0] a;
          a = 6'(c * WORDS + w);
          if (rom[a] == 32'hFFFF_FFFF) break;
          exp_q.push_back({a, rom[a], 2'(c)});
        end
      end
    end
    exp_n     = exp_q.size();
    exp_words = (exp_n > 255) ? 255 : exp_n;
  endtask

  task automatic fill_rom(input bit markers);
    for (int a = 0; a < 64; a++) begin
      rom[a] = $urandom;
      if (rom[a] == 32'hFFFF_FFFF) rom[a] = 32'h0;
    end
    if (markers)
      for (int c = 0; c < NUM_CHIPS; c++)
        if ($urandom_range(0, 1) == 1) rom[c * WORDS + $urandom_range(0, WORDS - 1)] = 32'hFFFF_FFFF;
  endtask

  // Monitor: per-cycle comparison of DUT activity against the model
  int         go_cnt, done_cnt, sync_width, sync_run, since_done;
  logic [3:0] chips_seen;
  bit         holding;
  logic [31:0] hold_word;
  logic [1:0]  hold_sel;
  logic       prev_go = 0, prev_sync = 0, prev_spi_done = 0;

  always @(negedge clk) begin
    if (!rst) begin
      if (!busy) holding = 0;
      if (spi_go) begin
        go_cnt++;
        chk("go_width", prev_go, 1'b0);
        chk("go_busy", busy, 1'b1);
        if (exp_q.size() == 0) begin
          chk("go_unexpected", 1, 0);
        end else begin
          mon_e = exp_q.pop_front();
          chk("go_addr", rom_addr, mon_e.addr);
          chk("go_word", spi_word, mon_e.data);
          chk("go_sel", spi_sel, mon_e.sel);
        end
        if (since_done >= 0) chk("go_gap", since_done >= GAP_CYCLES + 1, 1);
        hold_word = spi_word;
        hold_sel  = spi_sel;
        holding   = 1;
      end else if (holding) begin
        chk("word_hold", spi_word, hold_word);
        chk("sel_hold", spi_sel, hold_sel);
      end
      if (spi_done && !prev_spi_done) begin
        holding    = 0;
        since_done = 0;
      end else if (since_done >= 0) begin
        since_done++;
      end
      if (sync) begin
        if (!prev_sync) chk("sync_after_xfers", exp_q.size(), 0);
        sync_run++;
      end else if (prev_sync) begin
        sync_width = sync_run;
        sync_run   = 0;
      end
      if (done) begin
        done_cnt++;
        chk("done_after_sync", sync_width, SYNC_CYCLES);
        chk("done_busy_low", busy, 1'b0);
      end
      if (busy) chips_seen[rom_addr[5:4]] = 1'b1;
    end
    prev_go       = spi_go;
    prev_sync     = sync;
    prev_spi_done = spi_done;
  end

  task automatic check_reset(input string tag);
    chk({tag, "_rom_addr"}, rom_addr, 0);
    chk({tag, "_spi_word"}, spi_word, 0);
    chk({tag, "_spi_go"}, spi_go, 0);
    chk({tag, "_spi_sel"}, spi_sel, 0);
    chk({tag, "_sync"}, sync, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_error"}, error, 0);
    chk({tag, "_words"}, words_sent, 0);
  endtask

  task automatic start_seq(input logic [2:0] mask);
    build_model(mask);
    cur_mask   = mask;
    go_cnt     = 0;
    done_cnt   = 0;
    sync_width = -1;
    sync_run   = 0;
    since_done = -1;
    chips_seen = '0;
    holding    = 0;
    chip_mask  = mask;
    start      = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("start_busy", busy, 1'b1);
    chk("start_error_clr", error, 1'b0);
    chk("start_words_clr", words_sent, 0);
  endtask

  task automatic wait_go(input int n, input int budget);
    int k = 0;
    while (go_cnt < n && k < budget) begin
      @(negedge clk);
      k++;
    end
    chk("reach_go", go_cnt >= n, 1);
  endtask

  task automatic wait_end(input int budget, input bit glitch);
    int n = 0;
    while (done_cnt == 0 && n < budget) begin
      @(negedge clk);
      n++;
      if (start) start = 1'b0;
      else if (glitch && busy && $urandom_range(0, 40) == 0) start = 1'b1;
    end
    start = 1'b0;
    repeat (2) @(negedge clk);
    chk("seq_done_pulse", done_cnt, 1);
    chk("go_count", go_cnt, exp_n);
    chk("words_sent", words_sent, exp_words);
    chk("sync_width", sync_width, SYNC_CYCLES);
    chk("busy_end", busy, 1'b0);
    chk("sync_end", sync, 1'b0);
    if (cur_mask != 0) chk("chips_addressed", chips_seen, {1'b0, cur_mask});
  endtask

  initial begin
    #5_000_000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "global timeout");
  end

  initial begin
    int k, g0;
    logic pd;
    rst = 1'b1; start = 1'b0; abort = 1'b0; chip_mask = '0;
    fill_rom(0);
    repeat (3) @(negedge clk);
    check_reset("rst");
    rst = 1'b0;
    @(negedge clk);

    // Full tables on all three chips
    start_seq(3'b111);
    wait_end(5000, 0);
    chk("t1_go_lit", go_cnt, 48);
    chk("t1_words_lit", words_sent, 48);

    // Chip 1 only, end marker at word 3
    fill_rom(0);
    rom[16 + 3] = 32'hFFFF_FFFF;
    start_seq(3'b010);
    wait_end(2000, 0);
    chk("t2_go_lit", go_cnt, 3);
    chk("t2_words_lit", words_sent, 3);
    chk("t2_chips_lit", chips_seen, 4'b0010);

    // Empty mask: SYNC and DONE only
    start_seq(3'b000);
    wait_end(100, 0);
    chk("t3_go_lit", go_cnt, 0);
    chk("t3_words_lit", words_sent, 0);

    // ABORT in WAIT_DONE of chip 0 word 5, then restart
    fill_rom(0);
    start_seq(3'b111);
    wait_go(6, 1000);
    @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_busy", busy, 1'b0);
    chk("abort_sync", sync, 1'b0);
    chk("abort_go", spi_go, 1'b0);
    repeat (40) @(negedge clk);
    chk("abort_no_done", done_cnt, 0);
    chk("abort_no_more_go", go_cnt, 6);
    chk("abort_no_sync", sync_width, 32'hFFFF_FFFF);
    start_seq(3'b111);
    chk("restart_addr", rom_addr, 0);
    wait_end(5000, 0);
    chk("restart_go_lit", go_cnt, 48);

    // START during transfer 2 is ignored
    start_seq(3'b111);
    wait_go(2, 200);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("glitch_busy", busy, 1'b1);
    wait_end(5000, 0);
    chk("glitch_go_lit", go_cnt, 48);

    // RESET during GAP
    start_seq(3'b111);
    wait_go(3, 300);
    k  = 0;
    pd = spi_done;
    while (k < 100) begin
      @(negedge clk);
      k++;
      if (spi_done && !pd) break;
      pd = spi_done;
    end
    chk("reach_done_rise", k < 100, 1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_reset("gap_rst");
    rst = 1'b0;
    g0 = go_cnt;
    repeat (40) @(negedge clk);
    chk("post_rst_no_go", go_cnt, g0);
    chk("post_rst_busy", busy, 1'b0);

    // Randomised masks, tables, latencies and stray STARTs
    for (int it = 0; it < 8; it++) begin
      fill_rom(1);
      spi_lat = $urandom_range(1, 25);
      start_seq(3'($urandom_range(0, 7)));
      wait_end(6000, 1);
    end

`ifdef SPI_SEQ_TIMEOUT_EN
    // DONE stuck low: watchdog fires TIMEOUT clocks after the GO pulse
    spi_stuck = 1;
    spi_lat   = 20;
    start_seq(3'b111);
    k = 0;
    while (!spi_go && k < 50) begin
      @(negedge clk);
      k++;
    end
    chk("to_reach_go", spi_go, 1'b1);
    k = 0;
    while (!error && k < 200) begin
      @(negedge clk);
      k++;
    end
    chk("to_cycles", k, TIMEOUT + 1);
    chk("to_error", error, 1'b1);
    chk("to_busy", busy, 1'b0);
    repeat (10) @(negedge clk);
    chk("to_no_sync", sync_width, 32'hFFFF_FFFF);
    chk("to_no_done", done_cnt, 0);
    chk("to_error_sticky", error, 1'b1);
    spi_stuck = 0;
    start_seq(3'b001);
    wait_end(2000, 0);
    chk("to_error_after", error, 1'b0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/spi_clk_config_seq.md
Name: spi_clk_config_seq

Overview:
- Hardware sequencer that loads register tables into the three jitter-cleaner chips over the shared SPI engine, then issues the SYNC pulse.
- Sits between the wishbone register file and SPI_MODULE/SPI_MUX.
- Replaces per-word software pokes of SPI data/select/start with a single START command.
- Drives the SPI data word, GO and slave select; reads back DONE.

Parameters:
- NUM_CHIPS, 3, number of SPI slaves sequenced (chip index 0..NUM_CHIPS-1).
- WORD_AW, 4, address bits per chip table; WORDS_PER_CHIP = 2**WORD_AW.
- GAP_CYCLES, 2, idle cycles after each DONE before the next GO (1..255).
- SYNC_CYCLES, 4, SYNC high width in clocks (1..255).
- TIMEOUT_CYCLES, 64, DONE watchdog limit; used only with the optional feature.

Ports:
- CLK_1MHZ  in  1  SPI-domain clock; all logic on the rising edge.
- RESET  in  1  synchronous, active-high reset.
- START  in  1  single-cycle pulse that begins a sequence; ignored while BUSY.
- ABORT  in  1  level; returns the block to IDLE.
- CHIP_MASK  in  NUM_CHIPS  bit i=1: chip i is loaded; 0: chip i is skipped.
- ROM_ADDR  out  2+WORD_AW  {chip[1:0], word}; table ROM read address.
- ROM_DATA  in  32  table word; valid exactly 1 clock after ROM_ADDR.
- SPI_WORD  out  32  word to SPI_MODULE SPI_IN.
- SPI_GO  out  1  one-clock start pulse to SPI_MODULE.
- SPI_DONE  in  1  SPI_MODULE completion level.
- SPI_SEL  out  2  slave select to SPI_MUX.
- SYNC  out  1  active-high sync request; top level inverts it.
- BUSY  out  1  high from the START-accept cycle until the return to IDLE.
- DONE  out  1  one-clock pulse on successful completion.
- ERROR  out  1  sticky; cleared by RESET or the next accepted START.
- WORDS_SENT  out  8  count of words transferred this sequence.

Behaviour:
- Reset values: ROM_ADDR=0, SPI_WORD=0, SPI_GO=0, SPI_SEL=0, SYNC=0, BUSY=0, DONE=0, ERROR=0, WORDS_SENT=0, state=IDLE.
- RESET asserted mid-sequence forces reset values on the next edge; no GO is issued afterwards.
- IDLE:
  - On START with CHIP_MASK≠0: clear ERROR and WORDS_SENT, set BUSY, set chip = lowest set mask bit, word=0 -> FETCH.
  - On START with CHIP_MASK==0: go directly to SYNC_PULSE.
- FETCH: drive ROM_ADDR={chip,word} -> LOAD (1 wait clock for ROM latency).
- LOAD:
  - ROM_DATA==32'hFFFF_FFFF is the end-of-table marker: go to NEXT_CHIP, no transfer.
  - Otherwise: SPI_WORD<=ROM_DATA, SPI_SEL<=chip -> GO.
- GO: SPI_GO=1 for exactly one clock -> WAIT_DONE.
  - SPI_WORD and SPI_SEL stay stable from LOAD until the DONE rising edge.
- WAIT_DONE:
  - Wait for a rising edge of SPI_DONE, detected against its registered previous value. A DONE already high at GO is not accepted.
  - On the edge: WORDS_SENT+1 (saturates at 255) -> GAP.
- GAP:
  - Hold for GAP_CYCLES clocks.
  - Then, if word == WORDS_PER_CHIP-1 -> NEXT_CHIP; else word+1 -> FETCH.
- NEXT_CHIP:
  - Advance to the next higher set bit of CHIP_MASK (mask sampled at START), word=0 -> FETCH.
  - If no higher set bit remains -> SYNC_PULSE.
- SYNC_PULSE: SYNC=1 for SYNC_CYCLES clocks -> FINISH.
- FINISH: DONE=1 for one clock, BUSY=0 -> IDLE.
- ABORT (any non-IDLE state): next state IDLE, SPI_GO=0, SYNC=0, BUSY=0, no DONE pulse, ERROR unchanged. ABORT has priority over START in the same cycle.
- START while BUSY: ignored, no side effects.
- The sequence is complete after SYNC; no DONE pulse precedes the SYNC pulse.

Optional Feature:
- Macro SPI_SEQ_TIMEOUT_EN.
- Defined: a counter runs in WAIT_DONE. If TIMEOUT_CYCLES clocks pass without a DONE rising edge:
  - ERROR<=1 and return to IDLE, BUSY=0.
  - No SYNC and no DONE pulse.
  - The counter clears on entry to WAIT_DONE.
- Not defined: WAIT_DONE waits indefinitely; ERROR is tied to 0.

Test Plan:
1. CHIP_MASK=3'b111, full 16-word tables, SPI model DONE 20 clocks after GO:
   - expect 48 GO pulses in address order 0x00-0x0F, 0x10-0x1F, 0x20-0x2F, with SPI_SEL 0/1/2;
   - each GO ≥ GAP_CYCLES+1 clocks after the previous DONE edge;
   - SYNC high 4 clocks, then DONE pulse; WORDS_SENT=48.
2. CHIP_MASK=3'b010, chip1 table with marker at word 3: expect 3 transfers with SPI_SEL=1, chips 0/2 never addressed; WORDS_SENT=3, then SYNC and DONE.
3. CHIP_MASK=0: START -> SYNC high 4 clocks, DONE; zero GO pulses; WORDS_SENT=0.
4. ABORT mid-sequence: ABORT in WAIT_DONE of word 5 of chip 0 -> IDLE next clock; BUSY=0, no SYNC, no DONE. A later START restarts from address 0x00.
5. START pulsed during transfer 2 -> ignored; GO count still 48; RESET pulsed during GAP -> all outputs at reset values on the next clock.
6. SPI_SEQ_TIMEOUT_EN, SPI_DONE stuck low -> 64 clocks after the first GO: ERROR=1, BUSY=0, no SYNC. The next START clears ERROR.
